// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port (IF) and the load/store port (DM).
// DM wins ties, except that IF is forced through once DM has won STARVE_MAX times in a row while IF waited.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic [31:0] dm_rdata,
    output logic        dm_rvalid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state, state_next;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       owner_dm;
    logic       req_we;
    logic       last_beat;

    assign last_beat = (state == ACCESS) && (lat_cnt == 4'd0);
    assign mem_en    = (state == ACCESS);
    assign mem_we    = (state == ACCESS) && req_we;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && !(if_req && starve_cnt == STARVE_LIM)) dm_gnt = 1'b1;
                else if (if_req)                                     if_gnt = 1'b1;
                if (if_gnt || dm_gnt) state_next = ACCESS;
            end
            ACCESS: begin
                if (lat_cnt == 4'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request register doubles as the memory address/data drivers, so they hold between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            owner_dm   <= 1'b0;
            req_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            if_rdata   <= 32'd0;
            dm_rdata   <= 32'd0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
        end else begin
            if_rvalid <= last_beat && !owner_dm;
            dm_rvalid <= last_beat && owner_dm;

            if (dm_gnt) begin
                owner_dm  <= 1'b1;
                req_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                lat_cnt   <= LAT_INIT;
            end else if (if_gnt) begin
                owner_dm  <= 1'b0;
                req_we    <= 1'b0;
                mem_addr  <= if_addr;
                lat_cnt   <= LAT_INIT;
            end else if (state == ACCESS && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (state == IDLE) begin
                if (if_gnt)
                    starve_cnt <= 4'd0;
                else if (dm_gnt && if_req) begin
                    if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
                end else if (!if_req)
                    starve_cnt <= 4'd0;
            end

            // Stores leave dm_rdata untouched.
            if (last_beat) begin
                if (!owner_dm)    if_rdata <= mem_rdata;
                else if (!req_we) dm_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants/responses,
// negedge monitors pop and compare whenever the DUT presents a gnt or rvalid.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    // Second instance at MEM_LAT=1, DM port only.
    logic        if_req2, dm_req2, dm_we2;
    logic [31:0] if_addr2, dm_addr2, dm_wdata2;
    logic        if_gnt2, if_rvalid2, dm_gnt2, dm_rvalid2, mem_en2, mem_we2, busy2;
    logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2, mem_rdata2;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut2 (
        .clk(clk), .reset(reset),
        .if_req(if_req2), .if_addr(if_addr2), .if_gnt(if_gnt2), .if_rdata(if_rdata2), .if_rvalid(if_rvalid2),
        .dm_req(dm_req2), .dm_we(dm_we2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2), .dm_gnt(dm_gnt2),
        .dm_rdata(dm_rdata2), .dm_rvalid(dm_rvalid2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .busy(busy2)
    );

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } tx_t;
    typedef struct { logic is_dm; int c; } gexp_t;
    typedef struct { int c; logic [31:0] data; } rexp_t;

    tx_t   if_txq[$], dm_txq[$], dm2_txq[$];
    gexp_t gnt_q[$];
    int    gnt2_q[$];
    rexp_t if_rq[$], dm_rq[$], dm2_rq[$];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int t0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h40:  return 32'hCAFE0040;
            default: return a ^ 32'h5A5A0000;
        endcase
    endfunction

    always_comb mem_rdata  = memval(mem_addr);
    always_comb mem_rdata2 = memval(mem_addr2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Requesters: hold req with the head transaction until the monitor retires it on gnt.
    task automatic drive();
        if_req = (if_txq.size() != 0);
        if (if_req) if_addr = if_txq[0].addr;
        dm_req = (dm_txq.size() != 0);
        if (dm_req) begin
            dm_we    = dm_txq[0].we;
            dm_addr  = dm_txq[0].addr;
            dm_wdata = dm_txq[0].wdata;
        end
        dm_req2 = (dm2_txq.size() != 0);
        if (dm_req2) begin
            dm_we2    = dm2_txq[0].we;
            dm_addr2  = dm2_txq[0].addr;
            dm_wdata2 = dm2_txq[0].wdata;
        end
    endtask

    always @(posedge clk) begin
        #1;
        drive();
    end

    gexp_t g;
    rexp_t r1, r2, r3;

    always @(negedge clk) begin
        if (!reset) begin
            if (if_gnt && if_txq.size() != 0) void'(if_txq.pop_front());
            if (dm_gnt && dm_txq.size() != 0) void'(dm_txq.pop_front());
            if (if_gnt || dm_gnt) begin
                if (gnt_q.size() == 0) chk("spurious_gnt", 32'({if_gnt, dm_gnt}), 32'd0);
                else begin
                    g = gnt_q.pop_front();
                    chk("gnt_dm", 32'(dm_gnt), 32'(g.is_dm));
                    chk("gnt_if", 32'(if_gnt), 32'(!g.is_dm));
                    chk("gnt_cycle", 32'(cyc), 32'(g.c));
                end
            end
            if (if_rvalid) begin
                if (if_rq.size() == 0) chk("spurious_if_rvalid", 32'(if_rvalid), 32'd0);
                else begin
                    r1 = if_rq.pop_front();
                    chk("if_rvalid_cycle", 32'(cyc), 32'(r1.c));
                    chk("if_rdata", if_rdata, r1.data);
                end
            end
            if (dm_rvalid) begin
                if (dm_rq.size() == 0) chk("spurious_dm_rvalid", 32'(dm_rvalid), 32'd0);
                else begin
                    r2 = dm_rq.pop_front();
                    chk("dm_rvalid_cycle", 32'(cyc), 32'(r2.c));
                    chk("dm_rdata", dm_rdata, r2.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (dm_gnt2) begin
                if (dm2_txq.size() != 0) void'(dm2_txq.pop_front());
                if (gnt2_q.size() == 0) chk("spurious_gnt2", 32'(dm_gnt2), 32'd0);
                else chk("gnt2_cycle", 32'(cyc), 32'(gnt2_q.pop_front()));
            end
            if (if_gnt2 || if_rvalid2) chk("if2_activity", 32'({if_gnt2, if_rvalid2}), 32'd0);
            if (dm_rvalid2) begin
                if (dm2_rq.size() == 0) chk("spurious_dm_rvalid2", 32'(dm_rvalid2), 32'd0);
                else begin
                    r3 = dm2_rq.pop_front();
                    chk("dm2_rvalid_cycle", 32'(cyc), 32'(r3.c));
                    chk("dm2_rdata", dm_rdata2, r3.data);
                end
            end
        end
    end

    function automatic int pending();
        return if_txq.size() + dm_txq.size() + dm2_txq.size() + gnt_q.size() + gnt2_q.size()
             + if_rq.size() + dm_rq.size() + dm2_rq.size();
    endfunction

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_test();
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (pending() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(pending()), 32'd0);
        if_txq.delete(); dm_txq.delete(); dm2_txq.delete();
        gnt_q.delete(); gnt2_q.delete();
        if_rq.delete(); dm_rq.delete(); dm2_rq.delete();
        drive();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        if_req2 = 0; if_addr2 = 0; dm_req2 = 0; dm_we2 = 0; dm_addr2 = 0; dm_wdata2 = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single fetch
        start_test();
        if_txq.push_back('{1'b0, 32'h10, 32'h0});
        gnt_q.push_back('{1'b0, t0});
        if_rq.push_back('{t0 + 3, 32'hDEADBEEF});
        drive();
        at_cycle(t0 + 1);
        chk("fetch_c1_mem_en", 32'(mem_en), 32'd1);
        chk("fetch_c1_mem_addr", mem_addr, 32'h10);
        chk("fetch_c1_busy", 32'(busy), 32'd1);
        at_cycle(t0 + 2);
        chk("fetch_c2_mem_en", 32'(mem_en), 32'd1);
        chk("fetch_c2_mem_addr", mem_addr, 32'h10);
        at_cycle(t0 + 3);
        chk("fetch_c3_busy", 32'(busy), 32'd0);
        chk("fetch_c3_mem_en", 32'(mem_en), 32'd0);
        wait_done("fetch_drain");

        // Simultaneous requests: DM first, IF follows
        start_test();
        if_txq.push_back('{1'b0, 32'h30, 32'h0});
        dm_txq.push_back('{1'b0, 32'h40, 32'h0});
        gnt_q.push_back('{1'b1, t0});
        gnt_q.push_back('{1'b0, t0 + 3});
        dm_rq.push_back('{t0 + 3, 32'hCAFE0040});
        if_rq.push_back('{t0 + 6, 32'h5A5A0030});
        drive();
        wait_done("simul_drain");

        // Store: dm_rdata keeps the earlier load value
        start_test();
        dm_txq.push_back('{1'b1, 32'h20, 32'h1234});
        gnt_q.push_back('{1'b1, t0});
        dm_rq.push_back('{t0 + 3, 32'hCAFE0040});
        drive();
        at_cycle(t0 + 1);
        chk("store_c1_mem_we", 32'(mem_we), 32'd1);
        chk("store_c1_mem_wdata", mem_wdata, 32'h1234);
        chk("store_c1_mem_addr", mem_addr, 32'h20);
        at_cycle(t0 + 2);
        chk("store_c2_mem_we", 32'(mem_we), 32'd1);
        chk("store_c2_mem_wdata", mem_wdata, 32'h1234);
        at_cycle(t0 + 3);
        chk("store_c3_mem_we", 32'(mem_we), 32'd0);
        wait_done("store_drain");

        // Starvation guard: DM x4, then IF, then DM
        start_test();
        for (int i = 0; i < 5; i++) dm_txq.push_back('{1'b0, 32'h100 + 32'(4 * i), 32'h0});
        if_txq.push_back('{1'b0, 32'h200, 32'h0});
        gnt_q.push_back('{1'b1, t0});
        gnt_q.push_back('{1'b1, t0 + 3});
        gnt_q.push_back('{1'b1, t0 + 6});
        gnt_q.push_back('{1'b1, t0 + 9});
        gnt_q.push_back('{1'b0, t0 + 12});
        gnt_q.push_back('{1'b1, t0 + 15});
        dm_rq.push_back('{t0 + 3,  32'h5A5A0100});
        dm_rq.push_back('{t0 + 6,  32'h5A5A0104});
        dm_rq.push_back('{t0 + 9,  32'h5A5A0108});
        dm_rq.push_back('{t0 + 12, 32'h5A5A010C});
        dm_rq.push_back('{t0 + 18, 32'h5A5A0110});
        if_rq.push_back('{t0 + 15, 32'h5A5A0200});
        drive();
        wait_done("starve_drain");

        // Reset in the middle of a fetch; request still held afterwards
        start_test();
        if_txq.push_back('{1'b0, 32'h10, 32'h0});
        if_txq.push_back('{1'b0, 32'h10, 32'h0});
        gnt_q.push_back('{1'b0, t0});
        gnt_q.push_back('{1'b0, t0 + 3});
        if_rq.push_back('{t0 + 6, 32'hDEADBEEF});
        drive();
        at_cycle(t0 + 2);
        chk("prerst_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_done("reset_drain");

        // MEM_LAT=1 back-to-back loads
        start_test();
        dm2_txq.push_back('{1'b0, 32'h40, 32'h0});
        dm2_txq.push_back('{1'b0, 32'h44, 32'h0});
        dm2_txq.push_back('{1'b0, 32'h48, 32'h0});
        gnt2_q.push_back(t0);
        gnt2_q.push_back(t0 + 2);
        gnt2_q.push_back(t0 + 4);
        dm2_rq.push_back('{t0 + 2, 32'hCAFE0040});
        dm2_rq.push_back('{t0 + 4, 32'h5A5A0044});
        dm2_rq.push_back('{t0 + 6, 32'h5A5A0048});
        drive();
        wait_done("lat1_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
